// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32/RV64 opcode and funct3
// encodings, FSM state enum, access-size type and the funct3 legality check.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    // funct3[1:0] directly encodes log2 of the access size for both loads and stores.
    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_t;

    // 64-bit-only encodings (LD, LWU, SD) are rejected when wide is 0.
    function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3,
                                        input logic wide);
        if (is_load)
            return (f3 == 3'b111) || (!wide && (f3 == F3_LD || f3 == F3_LWU));
        return f3[2] || (!wide && f3 == F3_SD);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational address/lane logic for the load/store unit.
// Ports:
//   imm, funct3, op1, op2   - decoded immediate/funct3, base and store data
//   ea, off                 - effective address and byte offset within the lane
//   be, wdata, misalign     - byte enables, lane-shifted store data, alignment fault
//   ld_funct3, ld_off, rdata- registered load type/offset and raw memory data
//   ld_data                 - load value shifted down and sign/zero extended
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(NB)
) (
    input  logic [11:0]           imm,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic [OFFW-1:0]       off,
    output logic [NB-1:0]         be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  misalign,
    input  logic [2:0]            ld_funct3,
    input  logic [OFFW-1:0]       ld_off,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    mem_size_t             size;
    int                    nbytes;
    logic [NB-1:0]         mask;
    logic [DATA_WIDTH-1:0] sh;

    assign ea   = ADDR_WIDTH'(op1) + ADDR_WIDTH'($signed(imm));
    assign off  = ea[OFFW-1:0];
    assign size = mem_size_t'(funct3[1:0]);

    always_comb begin
        nbytes   = 8;
        misalign = |ea[2:0];
        case (size)
            BYTE:    begin nbytes = 1; misalign = 1'b0;     end
            HALF:    begin nbytes = 2; misalign = ea[0];    end
            WORD:    begin nbytes = 4; misalign = |ea[1:0]; end
            default: begin nbytes = 8; misalign = |ea[2:0]; end
        endcase
    end

    // Naturally aligned access never crosses a lane, so a plain shift suffices.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++)
            mask[i] = (i < nbytes);
    end

    assign be    = mask << off;
    assign wdata = op2 << {off, 3'b000};

    assign sh = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = sh;
        case (ld_funct3)
            F3_LB:   ld_data = DATA_WIDTH'($signed(sh[7:0]));
            F3_LH:   ld_data = DATA_WIDTH'($signed(sh[15:0]));
            F3_LW:   ld_data = DATA_WIDTH'($signed(sh[31:0]));
            F3_LBU:  ld_data = DATA_WIDTH'(sh[7:0]);
            F3_LHU:  ld_data = DATA_WIDTH'(sh[15:0]);
            F3_LWU:  ld_data = DATA_WIDTH'(sh[31:0]);
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: decodes loads/stores, issues one memory
// request at a time with req/gnt/rvalid handshake and returns extended
// load data for writeback.
// Ports:
//   clk_i, rst_i                     - clock, synchronous active-high reset
//   valid_i, inst_i, op1_i, op2_i    - issue interface (sampled only in IDLE)
//   busy_o                           - pipeline stall, high outside IDLE
//   mem_req_o .. mem_wdata_o         - memory request fields, held while req is up
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i - memory grant / response
//   done_o, reg_we_o, reg_wdata_o    - completion pulse and writeback
//   misalign_o, illegal_o            - one-cycle fault pulses
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [31:0]             inst_i,
    input  logic [DATA_WIDTH-1:0]   op1_i,
    input  logic [DATA_WIDTH-1:0]   op2_i,
    output logic                    busy_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    done_o,
    output logic                    reg_we_o,
    output logic [DATA_WIDTH-1:0]   reg_wdata_o,
    output logic                    misalign_o,
    output logic                    illegal_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e            state;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  is_load;
    logic                  is_store;
    logic [11:0]           imm;
    logic                  bad_enc;
    logic                  unused_bits;

    logic [ADDR_WIDTH-1:0] ea;
    logic [OFFW-1:0]       off;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  misalign;
    logic [DATA_WIDTH-1:0] ld_data;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB-1:0]         be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [OFFW-1:0]       off_q;
    logic                  err_ill;
    logic [DATA_WIDTH-1:0] rwd_q;

    assign opcode   = inst_i[6:0];
    assign funct3   = inst_i[14:12];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign imm      = is_store ? {inst_i[31:25], inst_i[11:7]} : inst_i[31:20];
    assign bad_enc  = f3_illegal(is_load, funct3, DATA_WIDTH == 64);

    // rs1 field: the register value arrives on op1_i already.
    assign unused_bits = ^inst_i[19:15];

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_align (
        .imm       (imm),
        .funct3    (funct3),
        .op1       (op1_i),
        .op2       (op2_i),
        .ea        (ea),
        .off       (off),
        .be        (be),
        .wdata     (wdata),
        .misalign  (misalign),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (mem_rdata_i),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            err_ill <= 1'b0;
            rwd_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i && (is_load || is_store)) begin
                        if (bad_enc || misalign) begin
                            // Illegal takes priority when both faults apply.
                            state   <= ST_ERR;
                            err_ill <= bad_enc;
                        end else begin
                            state   <= ST_REQ;
                            addr_q  <= {ea[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                            be_q    <= be;
                            wdata_q <= wdata;
                            we_q    <= is_store;
                            f3_q    <= funct3;
                            off_q   <= off;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (!we_q)
                            rwd_q <= ld_data;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (state != ST_IDLE);
    assign mem_req_o   = (state == ST_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign done_o      = (state == ST_RESP);
    assign reg_we_o    = (state == ST_RESP) && !we_q;
    assign reg_wdata_o = rwd_q;
    assign misalign_o  = (state == ST_ERR) && !err_ill;
    assign illegal_o   = (state == ST_ERR) && err_ill;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 32-bit instance
    logic        a_valid, a_busy, a_req, a_we, a_gnt, a_rvalid, a_done, a_rwe, a_mis, a_ill;
    logic [31:0] a_inst, a_op1, a_op2, a_addr, a_wdata, a_rdata, a_rwd;
    logic [3:0]  a_be;

    // 64-bit instance
    logic        b_valid, b_busy, b_req, b_we, b_gnt, b_rvalid, b_done, b_rwe, b_mis, b_ill;
    logic [31:0] b_inst;
    logic [63:0] b_op1, b_op2, b_addr, b_wdata, b_rdata, b_rwd;
    logic [7:0]  b_be;

    lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .inst_i(a_inst), .op1_i(a_op1),
        .op2_i(a_op2), .busy_o(a_busy), .mem_req_o(a_req), .mem_we_o(a_we),
        .mem_addr_o(a_addr), .mem_be_o(a_be), .mem_wdata_o(a_wdata), .mem_gnt_i(a_gnt),
        .mem_rvalid_i(a_rvalid), .mem_rdata_i(a_rdata), .done_o(a_done), .reg_we_o(a_rwe),
        .reg_wdata_o(a_rwd), .misalign_o(a_mis), .illegal_o(a_ill)
    );

    lsu_mem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .inst_i(b_inst), .op1_i(b_op1),
        .op2_i(b_op2), .busy_o(b_busy), .mem_req_o(b_req), .mem_we_o(b_we),
        .mem_addr_o(b_addr), .mem_be_o(b_be), .mem_wdata_o(b_wdata), .mem_gnt_i(b_gnt),
        .mem_rvalid_i(b_rvalid), .mem_rdata_i(b_rdata), .done_o(b_done), .reg_we_o(b_rwe),
        .reg_wdata_o(b_rwd), .misalign_o(b_mis), .illegal_o(b_ill)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (32-bit instance) ----------------
    localparam int K_IGN = 0, K_ILL = 1, K_MIS = 2, K_OK = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          off;
    } acc_t;

    function automatic acc_t model(input logic [31:0] inst, input logic [31:0] op1,
                                   input logic [31:0] op2);
        acc_t        m;
        logic [11:0] imm;
        logic [31:0] ea;
        int          size;
        bit          ld, st, legal;
        ld = (inst[6:0] == 7'h03);
        st = (inst[6:0] == 7'h23);
        m.f3 = inst[14:12];
        m.we = st;
        m.kind = K_IGN; m.addr = 0; m.be = 0; m.wdata = 0; m.off = 0;
        if (!ld && !st) return m;
        imm   = st ? {inst[31:25], inst[11:7]} : inst[31:20];
        ea    = op1 + {{20{imm[11]}}, imm};
        legal = ld ? (m.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (m.f3 inside {3'd0, 3'd1, 3'd2});
        size  = 1 << (m.f3 % 4);
        m.off   = int'(ea % 4);
        m.addr  = ea - m.off;
        m.be    = 4'(((1 << size) - 1) << m.off);
        m.wdata = op2 << (8 * m.off);
        if (!legal)              m.kind = K_ILL;
        else if (ea % size != 0) m.kind = K_MIS;
        else                     m.kind = K_OK;
        return m;
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input int off,
                                           input logic [31:0] rdata);
        int          nb;
        logic [31:0] v, mask;
        nb   = 1 << (f3 % 4);
        v    = rdata >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (f3 < 3'd4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] enc_ld(input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd1, f3, 5'd2, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_st(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    // ---------------- per-cycle expectations + compare process ----------------
    logic        e_on = 1'b0, e_zero = 1'b0;
    logic        e_busy, e_req, e_done, e_rwe, e_mis, e_ill, e_we;
    logic [31:0] e_addr, e_wdata, e_rwd;
    logic [3:0]  e_be;

    task automatic set_idle();
        e_zero = 0; e_busy = 0; e_req = 0; e_done = 0; e_rwe = 0; e_mis = 0; e_ill = 0;
    endtask

    always @(negedge clk) begin
        if (e_on) begin
            chk("busy", a_busy, e_busy);
            chk("mem_req", a_req, e_req);
            chk("done", a_done, e_done);
            chk("reg_we", a_rwe, e_rwe);
            chk("misalign", a_mis, e_mis);
            chk("illegal", a_ill, e_ill);
            if (e_req || e_zero) begin
                chk("mem_we", a_we, e_we);
                chk("mem_addr", a_addr, e_addr);
                chk("mem_be", a_be, e_be);
                if (e_we || e_zero) chk("mem_wdata", a_wdata, e_wdata);
            end
            if ((e_done && e_rwe) || e_zero) chk("reg_wdata", a_rwd, e_rwd);
        end
    end

    task automatic junk();
        logic [31:0] r;
        r = $urandom;
        a_valid = r[0];
        a_inst  = r[1] ? enc_ld(r[4:2], r[16:5]) : enc_st(r[4:2], r[16:5]);
        a_op1   = $urandom;
        a_op2   = $urandom;
    endtask

    task automatic run_access(input logic [31:0] inst, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] rdata,
                              input int gd, input int rd, input bit lit = 0,
                              input int l_err = 0, input logic [31:0] l_addr = 0,
                              input logic [3:0] l_be = 0, input logic [31:0] l_wd = 0,
                              input logic [31:0] l_rwd = 0);
        acc_t m;
        m = model(inst, op1, op2);
        set_idle();
        a_valid = 1; a_inst = inst; a_op1 = op1; a_op2 = op2; a_gnt = 0; a_rvalid = 0;
        @(posedge clk); #1;
        if (lit && l_err == 1) chk("lit_illegal", a_ill, 1);
        if (lit && l_err == 2) chk("lit_misalign", a_mis, 1);
        if (m.kind == K_IGN) begin
            a_valid = 0;
            return;
        end
        if (m.kind != K_OK) begin
            e_busy = 1; e_ill = (m.kind == K_ILL); e_mis = (m.kind == K_MIS);
            junk();
            @(posedge clk); #1;
            set_idle(); a_valid = 0;
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            e_busy = 1; e_req = 1; e_we = m.we; e_addr = m.addr; e_be = m.be; e_wdata = m.wdata;
            if (lit && k == 0) begin
                chk("lit_addr", a_addr, l_addr);
                chk("lit_be", a_be, l_be);
                if (m.we) chk("lit_wdata", a_wdata, l_wd);
            end
            junk();
            a_gnt    = (k == gd);
            a_rvalid = (k == gd) ? 1'b0 : 1'($urandom % 2);
            a_rdata  = $urandom;
            @(posedge clk); #1;
        end
        a_gnt = 0; e_req = 0;
        for (int k = 0; k <= rd; k++) begin
            junk();
            a_rvalid = (k == rd);
            a_rdata  = (k == rd) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        e_done = 1; e_rwe = !m.we;
        if (!m.we) e_rwd = ld_val(m.f3, m.off, rdata);
        if (lit && !m.we) chk("lit_reg_wdata", a_rwd, l_rwd);
        junk();
        a_rvalid = 1'($urandom % 2);
        a_rdata  = $urandom;
        @(posedge clk); #1;
        set_idle(); a_valid = 0; a_rvalid = 0;
    endtask

    task automatic run64(input logic [31:0] inst, input logic [63:0] op1, input logic [63:0] op2,
                         input logic [63:0] rdata, input bit is_load, input logic [63:0] x_addr,
                         input logic [7:0] x_be, input logic [63:0] x_wd, input logic [63:0] x_rwd);
        b_valid = 1; b_inst = inst; b_op1 = op1; b_op2 = op2;
        @(posedge clk); #1;
        b_valid = 0;
        chk("d64_req", b_req, 1);
        chk("d64_addr", b_addr, x_addr);
        chk("d64_be", b_be, x_be);
        if (!is_load) chk("d64_wdata", b_wdata, x_wd);
        b_gnt = 1;
        @(posedge clk); #1;
        b_gnt = 0;
        chk("d64_wait_req", b_req, 0);
        b_rvalid = 1; b_rdata = rdata;
        @(posedge clk); #1;
        b_rvalid = 0;
        chk("d64_done", b_done, 1);
        chk("d64_reg_we", b_rwe, is_load);
        if (is_load) chk("d64_reg_wdata", b_rwd, x_rwd);
        @(posedge clk); #1;
        chk("d64_busy_after", b_busy, 0);
    endtask

    initial begin
        logic [31:0] r, inst, op1;
        logic [11:0] imm;
        rst = 1;
        a_valid = 0; a_inst = 0; a_op1 = 0; a_op2 = 0; a_gnt = 0; a_rvalid = 0; a_rdata = 0;
        b_valid = 0; b_inst = 0; b_op1 = 0; b_op2 = 0; b_gnt = 0; b_rvalid = 0; b_rdata = 0;
        set_idle();
        e_zero = 1; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_rwd = 0;
        @(posedge clk); #1;
        e_on = 1;
        chk("rst_busy64", b_busy, 0);
        @(posedge clk); #1;
        rst = 0;
        set_idle();

        // LW 0x1000+4
        run_access(enc_ld(3'b010, 12'd4), 32'h1000, 32'h0, 32'hDEADBEEF, 0, 1,
                   1, 0, 32'h1004, 4'hF, 0, 32'hDEADBEEF);
        // SB / LBU / LB at offset 3
        run_access(enc_st(3'b000, 12'd0), 32'h2003, 32'hA5, 32'h0, 0, 0,
                   1, 0, 32'h2000, 4'b1000, 32'hA500_0000, 0);
        run_access(enc_ld(3'b100, 12'd0), 32'h2003, 32'h0, 32'h8000_0000, 0, 0,
                   1, 0, 32'h2000, 4'b1000, 0, 32'h0000_0080);
        run_access(enc_ld(3'b000, 12'd0), 32'h2003, 32'h0, 32'h8000_0000, 1, 0,
                   1, 0, 32'h2000, 4'b1000, 0, 32'hFFFF_FF80);
        // misaligned LH
        run_access(enc_ld(3'b001, 12'd1), 32'h1000, 32'h0, 32'h0, 0, 0, 1, 2);
        // grant stall of 5 cycles with valid toggling underneath
        run_access(enc_st(3'b001, 12'h002), 32'h4000, 32'hBEEF, 32'h0, 5, 2,
                   1, 0, 32'h4000, 4'b1100, 32'hBEEF_0000, 0);
        // 64-bit-only encodings on the 32-bit unit, and illegal+misaligned
        run_access(enc_ld(3'b011, 12'd0), 32'h8, 32'h0, 32'h0, 0, 0, 1, 1);
        run_access(enc_ld(3'b110, 12'd0), 32'h4, 32'h0, 32'h0, 0, 0, 1, 1);
        run_access(enc_st(3'b011, 12'd0), 32'h8, 32'h0, 32'h0, 0, 0, 1, 1);
        run_access(enc_st(3'b011, 12'd0), 32'h1, 32'h0, 32'h0, 0, 0, 1, 1);
        run_access(enc_ld(3'b111, 12'd0), 32'h0, 32'h0, 32'h0, 0, 0, 1, 1);
        run_access(enc_st(3'b100, 12'd0), 32'h0, 32'h0, 32'h0, 0, 0, 1, 1);
        // non-load/store opcode is ignored
        run_access(32'h0020_80B3, 32'h0, 32'h0, 32'h0, 0, 0);

        // reset while waiting for the response, then a late rvalid
        set_idle();
        a_valid = 1; a_inst = enc_ld(3'b010, 12'd0); a_op1 = 32'h3000; a_op2 = 0;
        @(posedge clk); #1;
        a_valid = 0; a_gnt = 1;
        e_busy = 1; e_req = 1; e_we = 0; e_addr = 32'h3000; e_be = 4'hF; e_wdata = 0;
        @(posedge clk); #1;
        a_gnt = 0; e_req = 0; rst = 1;
        @(posedge clk); #1;
        set_idle(); e_zero = 1; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_rwd = 0;
        rst = 0; a_rvalid = 1; a_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        a_rvalid = 0;
        @(posedge clk); #1;
        set_idle();
        run_access(enc_ld(3'b001, 12'd2), 32'h5000, 32'h0, 32'h8001_0000, 1, 0,
                   1, 0, 32'h5000, 4'b1100, 0, 32'hFFFF_8001);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r   = $urandom;
            op1 = $urandom;
            imm = 12'($urandom);
            if (r[9:8] != 2'b00) begin op1[1:0] = 2'b00; imm[1:0] = 2'b00; end
            if (r[3:0] == 0) begin
                inst = $urandom;
                inst[6:0] = 7'b0010011;
            end else if (r[4]) inst = enc_ld(r[7:5], imm);
            else               inst = enc_st(r[7:5], imm);
            run_access(inst, op1, $urandom, $urandom, int'(r[11:10]), int'(r[13:12]));
        end

        // 64-bit unit
        run64(enc_st(3'b011, 12'd8), 64'h0, 64'h1122_3344_5566_7788, 64'h0, 0,
              64'h8, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
        run64(enc_ld(3'b110, 12'd4), 64'h0, 64'h0, 64'hF000_0000_0000_0000, 1,
              64'h0, 8'hF0, 64'h0, 64'h0000_0000_F000_0000);
        run64(enc_ld(3'b011, 12'hFF8), 64'h18, 64'h0, 64'h8000_0000_0000_0001, 1,
              64'h10, 8'hFF, 64'h0, 64'h8000_0000_0000_0001);
        run64(enc_ld(3'b000, 12'd0), 64'h7, 64'h0, 64'h8000_0000_0000_0000, 1,
              64'h0, 8'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        run64(enc_st(3'b010, 12'd0), 64'hC, 64'hCAFE_BABE, 64'h0, 0,
              64'h8, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
